// File: rtl/rst_seq_gen_pkg.sv
// Shared types and helpers for the reset/run sequencer.
package rst_seq_gen_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Number of bits needed to count the values 0 .. value-1.
    function automatic int clog2(input longint value);
        longint v;
        int     w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rst_seq_gen_sync.sv
// Reset synchroniser: asserts immediately, deasserts after NUM clock edges.
module rst_sync #(
    parameter int NUM = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [NUM-1:0] r_sync;

    // Shift ones through the chain once the asynchronous reset has lifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[NUM-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset/run sequencer: hold, staggered channel release, timed run window.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGE_GAP   = 2,
    parameter int RUN_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               soft_rst,
    output logic [NUM_CH-1:0]  rst_out_n,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               run_done,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] LP_HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] LP_RUN_END      = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0] LP_CNT_ONE      = CNT_W'(1);
    localparam bit               LP_SKIP_RELEASE = (NUM_CH == 1) || (STAGE_GAP == 0);
    localparam bit               LP_RUN_FOREVER  = (RUN_CYCLES == 0);

    // Reject parameter sets the counters and channel vector cannot represent.
    if (NUM_CH < 1) begin : g_chk_num_ch
        $error("rst_seq_gen: NUM_CH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("rst_seq_gen: SYNC_STAGES must be at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold_min
        $error("rst_seq_gen: HOLD_CYCLES must be at least 1");
    end
    if (clog2(longint'(HOLD_CYCLES) + 1) > CNT_W) begin : g_chk_hold_w
        $error("rst_seq_gen: HOLD_CYCLES does not fit in CNT_W bits");
    end
    if (clog2(longint'(STAGE_GAP) + 1) > CNT_W) begin : g_chk_gap_w
        $error("rst_seq_gen: STAGE_GAP does not fit in CNT_W bits");
    end
    if (clog2(longint'(RUN_CYCLES) + 1) > CNT_W) begin : g_chk_run_w
        $error("rst_seq_gen: RUN_CYCLES does not fit in CNT_W bits");
    end

    logic              w_rst_sync_n;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CNT_W-1:0]  w_hold_cnt_nxt;
    logic [CNT_W-1:0]  r_gap_cnt;
    logic [CNT_W-1:0]  w_gap_cnt_nxt;
    logic [CNT_W-1:0]  r_cycle_cnt;
    logic [CNT_W-1:0]  w_cycle_cnt_nxt;
    logic [CNT_W-1:0]  w_cycle_inc;
    logic [NUM_CH-1:0] r_rst_out_n;
    logic [NUM_CH-1:0] w_rst_out_n_nxt;
    logic [NUM_CH-1:0] w_rel_step;
    logic              r_run_done;
    logic              w_run_done_nxt;

    rst_sync #(
        .NUM (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (w_rst_sync_n)
    );

    // Releasing one more channel shifts a one in from bit 0, keeping order ascending.
    assign w_rel_step  = (r_rst_out_n << 1) | NUM_CH'(1);
    assign w_cycle_inc = r_cycle_cnt + LP_CNT_ONE;

    // Next-state and next-output logic; soft_rst overrides every state.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_rst_out_n_nxt = r_rst_out_n;
        w_run_done_nxt  = r_run_done;

        if (soft_rst) begin
            w_state_nxt     = ST_HOLD;
            w_hold_cnt_nxt  = '0;
            w_gap_cnt_nxt   = '0;
            w_cycle_cnt_nxt = '0;
            w_rst_out_n_nxt = '0;
            w_run_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == LP_HOLD_LAST) begin
                        w_hold_cnt_nxt = '0;
                        w_gap_cnt_nxt  = '0;
                        if (LP_SKIP_RELEASE) begin
                            w_rst_out_n_nxt = '1;
                            w_cycle_cnt_nxt = '0;
                            w_state_nxt     = ST_RUN;
                        end else begin
                            w_rst_out_n_nxt = w_rel_step;
                            w_state_nxt     = ST_RELEASE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + LP_CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (r_gap_cnt == LP_GAP_LAST) begin
                        w_gap_cnt_nxt   = '0;
                        w_rst_out_n_nxt = w_rel_step;
                        if (w_rel_step[NUM_CH-1]) begin
                            w_cycle_cnt_nxt = '0;
                            w_state_nxt     = ST_RUN;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + LP_CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (LP_RUN_FOREVER) begin
                        if (r_cycle_cnt != '1) begin
                            w_cycle_cnt_nxt = w_cycle_inc;
                        end
                    end else begin
                        w_cycle_cnt_nxt = w_cycle_inc;
                        if (w_cycle_inc == LP_RUN_END) begin
                            w_run_done_nxt = 1'b1;
                            w_state_nxt    = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                end
            endcase
        end
    end

    // State and output registers, cleared as soon as the synchronised reset asserts.
    always_ff @(posedge clk or negedge w_rst_sync_n) begin
        if (!w_rst_sync_n) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_rst_out_n <= '0;
            r_run_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_rst_out_n <= w_rst_out_n_nxt;
            r_run_done  <= w_run_done_nxt;
        end
    end

    assign rst_out_n = r_rst_out_n;
    assign cycle_cnt = r_cycle_cnt;
    assign run_done  = r_run_done;
    assign state_o   = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default, no-gap and run-forever configurations.
module tb_rst_seq_gen;

    logic        clk;
    logic        rst_n;
    logic        soft_rst;

    logic [3:0]  defOut;
    logic [15:0] defCnt;
    logic        defDone;
    logic [1:0]  defState;

    logic [2:0]  gapOut;
    logic [15:0] gapCnt;
    logic        gapDone;
    logic [1:0]  gapState;

    logic [3:0]  forOut;
    logic [3:0]  forCnt;
    logic        forDone;
    logic [1:0]  forState;

    int nVectors;
    int nMiscompares;

    rst_seq_gen u_dut_def (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_rst  (soft_rst),
        .rst_out_n (defOut),
        .cycle_cnt (defCnt),
        .run_done  (defDone),
        .state_o   (defState)
    );

    rst_seq_gen #(
        .NUM_CH    (3),
        .STAGE_GAP (0)
    ) u_dut_gap0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_rst  (soft_rst),
        .rst_out_n (gapOut),
        .cycle_cnt (gapCnt),
        .run_done  (gapDone),
        .state_o   (gapState)
    );

    rst_seq_gen #(
        .RUN_CYCLES (0),
        .CNT_W      (4)
    ) u_dut_forever (
        .clk       (clk),
        .rst_n     (rst_n),
        .soft_rst  (soft_rst),
        .rst_out_n (forOut),
        .cycle_cnt (forCnt),
        .run_done  (forDone),
        .state_o   (forState)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-derived default-configuration values after edge k counted from the rst_n rise.
    function automatic logic [3:0] expDefOut(input int k);
        if (k >= 18)      return 4'b1111;
        else if (k >= 16) return 4'b0111;
        else if (k >= 14) return 4'b0011;
        else if (k >= 12) return 4'b0001;
        else              return 4'b0000;
    endfunction

    function automatic logic [1:0] expDefState(input int k);
        if (k < 12)      return 2'd0;
        else if (k < 18) return 2'd1;
        else if (k < 28) return 2'd2;
        else             return 2'd3;
    endfunction

    function automatic logic [15:0] expDefCnt(input int k);
        if (k < 18)      return 16'd0;
        else if (k < 28) return 16'(k - 18);
        else             return 16'd10;
    endfunction

    function automatic logic expDefDone(input int k);
        return (k >= 28);
    endfunction

    // Hold rst_n low for five edges, then release it just after a posedge.
    task automatic applyReset();
        rst_n    = 1'b0;
        soft_rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b1;
        soft_rst = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        nVectors++;
        if (defOut !== 4'b0000 || defState !== 2'd0 || defCnt !== 16'd0 || defDone !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_def: got out=%b st=%0d cnt=%0d done=%b expected out=0000 st=0 cnt=0 done=0",
                     defOut, defState, defCnt, defDone);
        end
        nVectors++;
        if (gapOut !== 3'b000 || gapState !== 2'd0 || gapCnt !== 16'd0 || gapDone !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_gap0: got out=%b st=%0d cnt=%0d done=%b expected out=000 st=0 cnt=0 done=0",
                     gapOut, gapState, gapCnt, gapDone);
        end
        repeat (3) @(posedge clk);
        #1;
        nVectors++;
        if (forOut !== 4'b0000 || forState !== 2'd0 || forCnt !== 4'd0 || forDone !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_forever: got out=%b st=%0d cnt=%0d done=%b expected out=0000 st=0 cnt=0 done=0",
                     forOut, forState, forCnt, forDone);
        end
    endtask

    task automatic test_default_sequence();
        applyReset();
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            nVectors++;
            if (defOut !== expDefOut(k)) begin
                nMiscompares++;
                $display("[TB] FAIL default rst_out_n edge %0d: got %b expected %b", k, defOut, expDefOut(k));
            end
            nVectors++;
            if (defState !== expDefState(k)) begin
                nMiscompares++;
                $display("[TB] FAIL default state edge %0d: got %0d expected %0d", k, defState, expDefState(k));
            end
            nVectors++;
            if (defCnt !== expDefCnt(k)) begin
                nMiscompares++;
                $display("[TB] FAIL default cycle_cnt edge %0d: got %0d expected %0d", k, defCnt, expDefCnt(k));
            end
            nVectors++;
            if (defDone !== expDefDone(k)) begin
                nMiscompares++;
                $display("[TB] FAIL default run_done edge %0d: got %b expected %b", k, defDone, expDefDone(k));
            end
        end
    endtask

    task automatic test_mid_run_reset();
        applyReset();
        repeat (22) @(posedge clk);
        #1;
        nVectors++;
        if (defCnt !== 16'd4 || defState !== 2'd2) begin
            nMiscompares++;
            $display("[TB] FAIL midrun_precond: got cnt=%0d st=%0d expected cnt=4 st=2", defCnt, defState);
        end
        #2 rst_n = 1'b0;
        #1;
        nVectors++;
        if (defOut !== 4'b0000 || defDone !== 1'b0 || defState !== 2'd0 || defCnt !== 16'd0) begin
            nMiscompares++;
            $display("[TB] FAIL midrun_async: got out=%b done=%b st=%0d cnt=%0d expected out=0000 done=0 st=0 cnt=0",
                     defOut, defDone, defState, defCnt);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            nVectors++;
            if (defOut !== expDefOut(k) || defState !== expDefState(k)) begin
                nMiscompares++;
                $display("[TB] FAIL midrun_repeat edge %0d: got out=%b st=%0d expected out=%b st=%0d",
                         k, defOut, defState, expDefOut(k), expDefState(k));
            end
            nVectors++;
            if (defCnt !== expDefCnt(k) || defDone !== expDefDone(k)) begin
                nMiscompares++;
                $display("[TB] FAIL midrun_repeat edge %0d: got cnt=%0d done=%b expected cnt=%0d done=%b",
                         k, defCnt, defDone, expDefCnt(k), expDefDone(k));
            end
        end
    endtask

    task automatic test_soft_rst_done();
        nVectors++;
        if (defState !== 2'd3) begin
            nMiscompares++;
            $display("[TB] FAIL softdone_precond: got st=%0d expected st=3", defState);
        end
        soft_rst = 1'b1;
        @(posedge clk);
        #1;
        nVectors++;
        if (defOut !== 4'b0000 || defCnt !== 16'd0 || defState !== 2'd0 || defDone !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL softdone_clear: got out=%b cnt=%0d st=%0d done=%b expected out=0000 cnt=0 st=0 done=0",
                     defOut, defCnt, defState, defDone);
        end
        soft_rst = 1'b0;
        for (int j = 1; j <= 22; j++) begin
            @(posedge clk);
            #1;
            nVectors++;
            if (defOut !== expDefOut(j + 2) || defState !== expDefState(j + 2) || defCnt !== expDefCnt(j + 2)) begin
                nMiscompares++;
                $display("[TB] FAIL softdone_seq edge +%0d: got out=%b st=%0d cnt=%0d expected out=%b st=%0d cnt=%0d",
                         j, defOut, defState, defCnt, expDefOut(j + 2), expDefState(j + 2), expDefCnt(j + 2));
            end
        end
    endtask

    task automatic test_soft_rst_held();
        applyReset();
        repeat (14) @(posedge clk);
        #1;
        nVectors++;
        if (defState !== 2'd1 || defOut !== 4'b0011) begin
            nMiscompares++;
            $display("[TB] FAIL softheld_precond: got st=%0d out=%b expected st=1 out=0011", defState, defOut);
        end
        soft_rst = 1'b1;
        for (int h = 0; h < 6; h++) begin
            @(posedge clk);
            #1;
            nVectors++;
            if (defOut !== 4'b0000 || defState !== 2'd0 || defCnt !== 16'd0) begin
                nMiscompares++;
                $display("[TB] FAIL softheld_hold cycle %0d: got out=%b st=%0d cnt=%0d expected out=0000 st=0 cnt=0",
                         h, defOut, defState, defCnt);
            end
        end
        soft_rst = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1;
            nVectors++;
            if (defOut !== expDefOut(j + 2) || defState !== expDefState(j + 2)) begin
                nMiscompares++;
                $display("[TB] FAIL softheld_seq edge +%0d: got out=%b st=%0d expected out=%b st=%0d",
                         j, defOut, defState, expDefOut(j + 2), expDefState(j + 2));
            end
        end
    endtask

    task automatic test_gap0();
        logic [2:0]  eOut;
        logic [1:0]  eState;
        logic [15:0] eCnt;
        logic        eDone;
        applyReset();
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            eOut   = (k >= 12) ? 3'b111 : 3'b000;
            eState = (k < 12) ? 2'd0 : ((k < 22) ? 2'd2 : 2'd3);
            eCnt   = (k < 12) ? 16'd0 : ((k < 22) ? 16'(k - 12) : 16'd10);
            eDone  = (k >= 22);
            nVectors++;
            if (gapOut !== eOut || gapState !== eState) begin
                nMiscompares++;
                $display("[TB] FAIL gap0 edge %0d: got out=%b st=%0d expected out=%b st=%0d",
                         k, gapOut, gapState, eOut, eState);
            end
            nVectors++;
            if (gapCnt !== eCnt || gapDone !== eDone) begin
                nMiscompares++;
                $display("[TB] FAIL gap0 edge %0d: got cnt=%0d done=%b expected cnt=%0d done=%b",
                         k, gapCnt, gapDone, eCnt, eDone);
            end
        end
    endtask

    task automatic test_run_forever();
        logic [1:0] eState;
        logic [3:0] eCnt;
        applyReset();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            eState = (k < 12) ? 2'd0 : ((k < 18) ? 2'd1 : 2'd2);
            eCnt   = (k < 18) ? 4'd0 : ((k - 18 > 15) ? 4'd15 : 4'(k - 18));
            nVectors++;
            if (forOut !== expDefOut(k) || forState !== eState) begin
                nMiscompares++;
                $display("[TB] FAIL forever edge %0d: got out=%b st=%0d expected out=%b st=%0d",
                         k, forOut, forState, expDefOut(k), eState);
            end
            nVectors++;
            if (forCnt !== eCnt || forDone !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL forever edge %0d: got cnt=%0d done=%b expected cnt=%0d done=0",
                         k, forCnt, forDone, eCnt);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst_n        = 1'b1;
        soft_rst     = 1'b0;
        test_reset();
        test_default_sequence();
        test_mid_run_reset();
        test_soft_rst_done();
        test_soft_rst_held();
        test_gap0();
        test_run_forever();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
